fx_mul: RTL
===========

# fx_mul

Pipelined signed fixed-point multiplier in QINT.QFRAC format, the companion of the fixed-point divider in the math library. It feeds the regression and pricing datapaths. It accepts operand pairs under a valid/ready handshake and returns rounded products in order, with a fixed latency when not stalled. Unlike the divider, it honours downstream backpressure, so it can sit directly in front of stalling consumers.

## Interface
- WIDTH, 32: operand and result width in bits.
- QINT, 16: integer bits, including sign.
- QFRAC, WIDTH-QINT: fractional bits; must be ≥1.
- LATENCY, 3: pipeline depth in register stages; must be ≥1.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_in  in  1  operand pair a/b present.
- ready_out  out  1  block can accept on this edge.
- a  in  WIDTH  signed multiplicand, QINT.QFRAC.
- b  in  WIDTH  signed multiplier, QINT.QFRAC.
- valid_out  out  1  result/overflow valid.
- ready_in  in  1  downstream accepts result on this edge.
- result  out  WIDTH  signed product, QINT.QFRAC.
- overflow  out  1  product not representable in WIDTH bits; qualified by valid_out.

## Operation
- Accept on a rising edge when valid_in && ready_out.
- Arithmetic:
  - Compute p = a*b as a full 2*WIDTH signed product.
  - Round: r = p + 2^(QFRAC-1), i.e. round half toward +inf.
  - Shift: s = r >>> QFRAC, arithmetic, in 2*WIDTH bits.
  - overflow = 1 when s is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Pipeline:
  - LATENCY stages, each holding a valid bit and data.
  - Multiply, round and saturate logic may be distributed across stages freely.
  - The output stage drives valid_out, result and overflow directly from registers.
- Flow control uses a global stall:
  - stall = valid_out && !ready_in.
  - ready_out = !stall. This is a combinational path from ready_in and is permitted.
  - While stalled, no stage advances. valid_out, result and overflow hold stable.
  - When not stalled, every stage advances each edge. Empty stages (bubbles) advance too; they are not collapsed.
- Ordering: results emerge in acceptance order. No drops, no duplicates.
- Reset (rst_n low, at any time, including mid-stream):
  - All valid bits clear immediately.
  - valid_out = 0, result = 0, overflow = 0.
  - In-flight operations are discarded and never appear after reset release.
- valid_in while ready_out is 0: not accepted. The upstream holds a/b; the block must not sample them.

## Timing
- Latency, unstalled:
  - Counting the accepting edge as edge 1, valid_out rises after edge LATENCY.
  - For LATENCY=3: accept at edge n, valid_out high after edge n+2.
- Throughput: one operation per cycle while ready_in stays high.
- Each cycle that stall is high adds exactly one cycle to the latency of every in-flight operation.
- Handshake completes on an edge with valid_out && ready_in. If no new result arrives behind it, valid_out drops after that edge.
- Simultaneous accept and deliver on one edge is supported with no bubble.
- Reset values: ready_out = 1 (valid_out = 0), valid_out = 0, result = 0, overflow = 0.

## Configuration
- FXMUL_SAT_EN defined: on overflow, result clamps to 2^(WIDTH-1)-1 for positive s and -2^(WIDTH-1) for negative s; overflow = 1.
- FXMUL_SAT_EN undefined: result = s[WIDTH-1:0] (wraps); overflow is still computed and reported identically.
- Latency and handshake are identical in both builds.

## Test plan
All cases use defaults: WIDTH=32, QINT=16.
- Basic multiply: a=0x00018000 (1.5), b=0x00020000 (2.0), ready_in=1 → result 0x00030000, overflow 0, valid_out high after edge n+2 for acceptance at edge n.
- Sign: a=0xFFFE8000 (-1.5), b=0x00020000 → 0xFFFD0000. a=0xFFFF0000, b=0xFFFF0000 → 0x00010000.
- Rounding: a=0x00000001, b=0x00008000 → 0x00000001. a=0x00000001, b=0x00007FFF → 0x00000000. a=0xFFFFFFFF, b=0x00008000 → 0x00000000.
- Overflow:
  - a=b=0x01000000 (256.0): overflow 1; result 0x7FFFFFFF with FXMUL_SAT_EN, 0x00000000 without.
  - a=0xFF000000, b=0x01000000: result 0x80000000 with FXMUL_SAT_EN, overflow 1.
- Backpressure: stream 5 back-to-back pairs (k·1.0 × 2.0, k=1..5). Drop ready_in for 4 cycles at the first valid_out.
  - ready_out is low throughout the stall; result stays 0x00020000.
  - After release, outputs 0x00020000, 0x00040000, …, 0x000A0000 appear in order, each exactly once.
- Reset mid-flight: accept 2 operations, then pulse rst_n low for 1 cycle before either completes → valid_out, result and overflow are 0 immediately; no valid_out for 10 cycles after release; a subsequent operation completes normally.

Source files
------------

// File: rtl/fx_mul.sv
// Pipelined signed QINT.QFRAC multiplier with round-half-up, overflow flag and global-stall backpressure.
// Define FXMUL_SAT_EN to clamp overflowing products instead of wrapping them.
module fx_mul #(
  parameter int WIDTH   = 32,
  parameter int QINT    = 16,
  parameter int QFRAC   = WIDTH - QINT,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int PW = 2 * WIDTH;

  // Handshake: a pair is taken on an edge with valid_in && ready_out; a result is
  // handed over on an edge with valid_out && ready_in. When the output is held
  // (valid_out && !ready_in) the whole pipeline freezes, bubbles included.
  logic stall;

  logic signed [PW-1:0] a_ext, b_ext, prod, rnd, shf;
  logic                 ovf_c;
  logic [WIDTH-1:0]     res_c;

  logic [LATENCY-1:0]   vld_q;
  logic [WIDTH-1:0]     res_q [LATENCY];
  logic                 ovf_q [LATENCY];

  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    prod  = a_ext * b_ext;
    rnd   = prod + (PW'(1) << (QFRAC - 1));
    shf   = rnd >>> QFRAC;
    // Representable iff every bit from the result sign bit upward matches.
    ovf_c = !((&shf[PW-1:WIDTH-1]) || !(|shf[PW-1:WIDTH-1]));
`ifdef FXMUL_SAT_EN
    if (ovf_c) begin
      res_c = shf[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_c = shf[WIDTH-1:0];
    end
`else
    res_c = shf[WIDTH-1:0];
`endif
  end

  assign valid_out = vld_q[LATENCY-1];
  assign result    = res_q[LATENCY-1];
  assign overflow  = ovf_q[LATENCY-1];
  assign stall     = valid_out && !ready_in;
  assign ready_out = !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      vld_q[0] <= valid_in;
      // Operands are only captured on an actual accept.
      if (valid_in) begin
        res_q[0] <= res_c;
        ovf_q[0] <= ovf_c;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

endmodule
